fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the pipelined CPU. Drives PC requests to instruction memory over a
//  req/rdy handshake (variable latency, one request outstanding) and buffers up to 2 returned words.
//  Presents pc_inst/pc_next/inst_valid to the IF/ID register and the decode stage. Accepts branch
//  redirects (taken target) back from decode, and stops fetching after a HLT word.
// PARAMETERS
//  RESET_PC    16'h0000  fetch address after reset
//  HLT_OPCODE  4'hF      opcode (inst[15:12]) that stops fetching
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous active-low reset
//  imem_req       out  1   request valid; imem_addr valid while high
//  imem_addr      out  16  fetch address (byte address, word aligned)
//  imem_rdy       in   1   completes request in cycle imem_req&&imem_rdy
//  imem_data      in   16  instruction word, valid when imem_rdy
//  stall          in   1   IF/ID hold: head entry not consumed this cycle
//  redirect       in   1   taken branch from decode (is_branch&&taken)
//  redirect_pc    in   16  branch target, valid with redirect
//  inst_valid     out  1   head entry valid
//  pc_inst        out  16  head instruction word
//  pc_next        out  16  head address + 2
//  halted         out  1   HLT fetched, no request outstanding
// BEHAVIOUR
//  - Reset (rst_n low at posedge): fetch_pc=RESET_PC, buffer count=0, discard=0, halt_seen=0;
//    inst_valid=0, pc_inst=0, pc_next=0, imem_req=0, halted=0. Outstanding request abandoned.
//  - Handshake: once imem_req rises, it and imem_addr stay stable until imem_req&&imem_rdy.
//    A new request starts only if count<2 (after this cycle's dequeue), halt_seen=0, and no redirect this cycle.
//    Back-to-back: with rdy=1 each cycle, imem_req stays high and addr advances every cycle.
//  - Completion: fetch_pc+=2 (16-bit wrap, 0xFFFE->0x0000). If discard=1, drop word, clear discard.
//    Otherwise enqueue {imem_data, addr+2}; visible at the head on the NEXT cycle (1-cycle latency, no bypass).
//  - Buffer: 2-entry FIFO (head + skid). Dequeue when inst_valid && !stall. Enqueue and dequeue
//    in the same cycle is legal at any count. Never overflows, because of the count<2 start rule.
//  - Redirect (priority over stall and completion): flush buffer (count=0, inst_valid=0 next cycle),
//    fetch_pc=redirect_pc, clear halt_seen. If a request is outstanding and not completing this cycle,
//    set discard; otherwise, a word completing this cycle is dropped. Next request goes to redirect_pc.
//  - HLT: when an enqueued word has inst[15:12]==HLT_OPCODE, set halt_seen. No further requests start.
//    The HLT word is still delivered. halted = halt_seen && !imem_req; held until redirect or reset.
//  - Low bit of redirect_pc is passed through unchanged (alignment is the caller's responsibility).
// TESTING
//  1. Reset, rdy=1, stall=0 -> req from cycle 1, addr 0x0000,0x0002,0x0004...; inst_valid from
//     cycle 2 with pc_inst=mem[0], pc_next=0x0002, one instruction per cycle.
//  2. rdy=1, stall high 3 cycles -> count reaches 2, imem_req drops; after release, words
//     delivered in order with no loss or duplicate, then fetch resumes.
//  3. rdy latency 3, redirect to 0x0040 while 0x0006 outstanding -> addr holds 0x0006 until rdy;
//     that word is dropped; next addr 0x0040; first valid pc_inst=mem[0x40], pc_next=0x0042.
//  4. mem[0x0008]=16'hF000 -> no request for 0x000A; HLT delivered; halted=1 the cycle after
//     capture and stays high; redirect to 0x0000 clears halted and fetch restarts at 0x0000.
//  5. Redirect in the same cycle as rdy with stall=1, count=2 -> buffer flushed, word dropped,
//     inst_valid=0 next cycle, next req addr=redirect_pc.
//  6. rst_n low mid-request (latency 4) -> next cycle all outputs 0; after rst_n high, req at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Issues word fetches to instruction memory over a
//   req/rdy handshake (one request outstanding, variable latency), buffers up
//   to two returned words in a small FIFO and presents the head entry to the
//   IF/ID register. Taken-branch redirects from decode flush the buffer and
//   re-steer fetch. Fetching stops after an HLT word has been captured.
//
// Ports
//   clk          in   1   system clock
//   rst_n        in   1   synchronous active-low reset
//   imem_req     out  1   request valid; imem_addr valid while high
//   imem_addr    out  16  fetch byte address
//   imem_rdy     in   1   request completes in a cycle with imem_req && imem_rdy
//   imem_data    in   16  instruction word, valid with imem_rdy
//   stall        in   1   head entry is not consumed this cycle
//   redirect     in   1   taken branch from decode
//   redirect_pc  in   16  branch target, valid with redirect
//   inst_valid   out  1   head entry valid
//   pc_inst      out  16  head instruction word
//   pc_next      out  16  head address + 2
//   halted       out  1   HLT captured and no request outstanding
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] pc_inst,
    output logic [15:0] pc_next,
    output logic        halted
);

    localparam int DEPTH = 2;

    // Request / control state
    logic        req_q,       req_d;
    logic [15:0] addr_q,      addr_d;
    logic [15:0] fetch_pc_q,  fetch_pc_d;
    logic        discard_q,   discard_d;
    logic        halt_seen_q, halt_seen_d;
    logic [1:0]  count_q,     count_d;

    // Buffer storage: entry 0 is the head, entry 1 the skid slot
    logic [15:0] buf_inst_q [DEPTH];
    logic [15:0] buf_inst_d [DEPTH];
    logic [15:0] buf_pc_q   [DEPTH];
    logic [15:0] buf_pc_d   [DEPTH];

    logic        complete;
    logic        deq;
    logic        enq;
    logic [15:0] enq_pc;

    assign complete = req_q & imem_rdy;
    assign deq      = (count_q != 2'd0) & ~stall;
    // A completing word is kept only if it is not a leftover from before a
    // redirect and no redirect is flushing the buffer this cycle.
    assign enq      = complete & ~discard_q & ~redirect;
    assign enq_pc   = addr_q + 16'd2;

    always_comb begin
        req_d       = req_q;
        addr_d      = addr_q;
        fetch_pc_d  = fetch_pc_q;
        discard_d   = discard_q;
        halt_seen_d = halt_seen_q;
        count_d     = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            buf_inst_d[i] = buf_inst_q[i];
            buf_pc_d[i]   = buf_pc_q[i];
        end

        if (redirect) begin
            count_d     = 2'd0;
            fetch_pc_d  = redirect_pc;
            halt_seen_d = 1'b0;
            if (req_q && !complete) begin
                // Handshake must stay stable: keep the old request on the
                // bus and throw its word away when it finally returns.
                discard_d = 1'b1;
            end else begin
                req_d     = 1'b0;
                discard_d = 1'b0;
            end
        end else begin
            if (complete) begin
                req_d = 1'b0;
                if (discard_q) begin
                    // fetch_pc already points at the redirect target
                    discard_d = 1'b0;
                end else begin
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    if (imem_data[15:12] == HLT_OPCODE) begin
                        halt_seen_d = 1'b1;
                    end
                end
            end

            unique case ({deq, enq})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        buf_inst_d[0] = buf_inst_q[1];
                        buf_pc_d[0]   = buf_pc_q[1];
                        buf_inst_d[1] = imem_data;
                        buf_pc_d[1]   = enq_pc;
                    end else begin
                        buf_inst_d[0] = imem_data;
                        buf_pc_d[0]   = enq_pc;
                    end
                end
                2'b10: begin
                    buf_inst_d[0] = buf_inst_q[1];
                    buf_pc_d[0]   = buf_pc_q[1];
                    count_d       = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        buf_inst_d[0] = imem_data;
                        buf_pc_d[0]   = enq_pc;
                    end else begin
                        buf_inst_d[1] = imem_data;
                        buf_pc_d[1]   = enq_pc;
                    end
                    count_d = count_q + 2'd1;
                end
                default: begin
                end
            endcase

            // Start only when the buffer will still have room after the
            // word of this request lands; uses post-enqueue occupancy and
            // the halt flag including an HLT captured this very cycle.
            if (!req_d && (count_d < 2'd2) && !halt_seen_d) begin
                req_d  = 1'b1;
                addr_d = fetch_pc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q       <= 1'b0;
            addr_q      <= 16'h0000;
            fetch_pc_q  <= RESET_PC;
            discard_q   <= 1'b0;
            halt_seen_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            req_q       <= req_d;
            addr_q      <= addr_d;
            fetch_pc_q  <= fetch_pc_d;
            discard_q   <= discard_d;
            halt_seen_q <= halt_seen_d;
            count_q     <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    buf_inst_q[gi] <= 16'h0000;
                    buf_pc_q[gi]   <= 16'h0000;
                end else begin
                    buf_inst_q[gi] <= buf_inst_d[gi];
                    buf_pc_q[gi]   <= buf_pc_d[gi];
                end
            end
        end
    endgenerate

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != 2'd0);
    assign pc_inst    = buf_inst_q[0];
    assign pc_next    = buf_pc_q[0];
    assign halted     = halt_seen_q & ~req_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] pc_inst;
    logic [15:0] pc_next;
    logic        halted;

    logic [15:0] mem [0:32767];

    int n_chk  = 0;
    int n_fail = 0;

    assign imem_data = mem[imem_addr[15:1]];

    fetch_unit #(.RESET_PC(RESET_PC), .HLT_OPCODE(4'hF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .pc_inst     (pc_inst),
        .pc_next     (pc_next),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model: queue of delivered words ----------
    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pcn;
    } ent_t;

    ent_t        mq[$];
    logic        m_req;
    logic [15:0] m_addr;
    logic [15:0] m_pc;
    logic        m_disc;
    logic        m_halt;
    logic        m_rst;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        done;
        logic [15:0] w;
        if (!rst_n) begin
            mq.delete();
            m_req  = 1'b0;
            m_addr = 16'h0000;
            m_pc   = RESET_PC;
            m_disc = 1'b0;
            m_halt = 1'b0;
            m_rst  = 1'b1;
            return;
        end
        m_rst = 1'b0;
        done  = m_req && imem_rdy;
        if (redirect) begin
            mq.delete();
            m_halt = 1'b0;
            m_pc   = redirect_pc;
            if (done) begin
                m_req  = 1'b0;
                m_disc = 1'b0;
            end else if (m_req) begin
                m_disc = 1'b1;
            end
        end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (done) begin
                m_req = 1'b0;
                if (m_disc) begin
                    m_disc = 1'b0;
                end else begin
                    w = mem[m_addr[15:1]];
                    mq.push_back('{inst: w, pcn: m_addr + 16'd2});
                    if (w[15:12] == 4'hF) m_halt = 1'b1;
                    m_pc = m_addr + 16'd2;
                end
            end
            if (!m_req && mq.size() < 2 && !m_halt) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic compare_model();
        chk("model req", 16'(imem_req), 16'(m_req));
        if (m_req) chk("model addr", imem_addr, m_addr);
        chk("model valid", 16'(inst_valid), 16'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("model pc_inst", pc_inst, mq[0].inst);
            chk("model pc_next", pc_next, mq[0].pcn);
        end
        chk("model halted", 16'(halted), 16'(m_halt && !m_req));
        if (m_rst) begin
            chk("reset addr", imem_addr, 16'h0000);
            chk("reset pc_inst", pc_inst, 16'h0000);
            chk("reset pc_next", pc_next, 16'h0000);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_rdy = 1'b0;
        tick();
        tick();
        chk("rst req", 16'(imem_req), 16'd0);
        chk("rst valid", 16'(inst_valid), 16'd0);
        chk("rst halted", 16'(halted), 16'd0);
        rst_n = 1'b1;
    endtask

    task automatic fill_seq();
        for (int w = 0; w < 32768; w++) begin
            logic [15:0] wv;
            wv = 16'(w);
            mem[w] = {4'h1, wv[11:0]};
        end
    endtask

    typedef struct {
        logic        stall;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_val;
        logic [15:0] e_inst;
        logic [15:0] e_pcn;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic s, logic r, logic q, logic [15:0] a,
                                logic v, logic [15:0] ins, logic [15:0] pn);
        vec_t t;
        t.stall = s; t.rdy = r; t.e_req = q; t.e_addr = a;
        t.e_val = v; t.e_inst = ins; t.e_pcn = pn;
        return t;
    endfunction

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_rdy    = 1'b0;
        mem[0]      = 16'h0000;

        // Streaming after reset, then a three-cycle stall filling the buffer
        tbl[0] = mk(0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[1] = mk(0, 1, 1, 16'h0002, 1, 16'h1000, 16'h0002);
        tbl[2] = mk(0, 1, 1, 16'h0004, 1, 16'h1001, 16'h0004);
        tbl[3] = mk(0, 1, 1, 16'h0006, 1, 16'h1002, 16'h0006);
        tbl[4] = mk(1, 1, 0, 16'h0000, 1, 16'h1002, 16'h0006);
        tbl[5] = mk(1, 1, 0, 16'h0000, 1, 16'h1002, 16'h0006);
        tbl[6] = mk(1, 1, 0, 16'h0000, 1, 16'h1002, 16'h0006);
        tbl[7] = mk(0, 1, 1, 16'h0008, 1, 16'h1003, 16'h0008);
        tbl[8] = mk(0, 1, 1, 16'h000A, 1, 16'h1004, 16'h000A);
        tbl[9] = mk(0, 1, 1, 16'h000C, 1, 16'h1005, 16'h000C);

        fill_seq();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            stall    = tbl[i].stall;
            imem_rdy = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d req", i), 16'(imem_req), 16'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d valid", i), 16'(inst_valid), 16'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("vec%0d inst", i), pc_inst, tbl[i].e_inst);
                chk($sformatf("vec%0d pcn", i), pc_next, tbl[i].e_pcn);
            end
            $display("vec %0d: req=%b addr=%h valid=%b inst=%h pcn=%h",
                     i, imem_req, imem_addr, inst_valid, pc_inst, pc_next);
        end

        // Redirect while 0x0006 is outstanding and memory is slow
        do_reset();
        imem_rdy = 1'b1;
        repeat (4) tick();
        chk("t3 addr6", imem_addr, 16'h0006);
        imem_rdy = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("t3 hold req", 16'(imem_req), 16'd1);
        chk("t3 hold addr", imem_addr, 16'h0006);
        chk("t3 flushed", 16'(inst_valid), 16'd0);
        tick();
        chk("t3 still held", imem_addr, 16'h0006);
        imem_rdy = 1'b1;
        tick();
        chk("t3 target addr", imem_addr, 16'h0040);
        chk("t3 dropped", 16'(inst_valid), 16'd0);
        tick();
        chk("t3 first valid", 16'(inst_valid), 16'd1);
        chk("t3 first inst", pc_inst, 16'h1020);
        chk("t3 first pcn", pc_next, 16'h0042);
        $display("redirect-while-outstanding: inst=%h pcn=%h", pc_inst, pc_next);

        // HLT at 0x0008
        mem[4] = 16'hF000;
        do_reset();
        imem_rdy = 1'b1;
        repeat (6) tick();
        chk("t4 no req", 16'(imem_req), 16'd0);
        chk("t4 hlt head", pc_inst, 16'hF000);
        chk("t4 hlt pcn", pc_next, 16'h000A);
        chk("t4 halted", 16'(halted), 16'd1);
        repeat (3) begin
            tick();
            chk("t4 halted held", 16'(halted), 16'd1);
            chk("t4 idle", 16'(imem_req), 16'd0);
        end
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("t4 unhalt", 16'(halted), 16'd0);
        tick();
        chk("t4 restart req", 16'(imem_req), 16'd1);
        chk("t4 restart addr", imem_addr, 16'h0000);
        $display("hlt: restart addr=%h halted=%b", imem_addr, halted);
        mem[4] = 16'h1004;

        // Redirect with a stalled buffer, including a completing word
        do_reset();
        imem_rdy = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("t5 flush valid", 16'(inst_valid), 16'd0);
        chk("t5 flush req", 16'(imem_req), 16'd0);
        tick();
        chk("t5 target", imem_addr, 16'h0100);
        repeat (2) tick();
        chk("t5 full req", 16'(imem_req), 16'd0);
        chk("t5 full head", pc_inst, 16'h1080);
        redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        chk("t5 full flush", 16'(inst_valid), 16'd0);
        tick();
        chk("t5 full target", imem_addr, 16'h0200);
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap addr fffc", imem_addr, 16'hFFFC);
        tick();
        chk("wrap addr fffe", imem_addr, 16'hFFFE);
        chk("wrap pcn fffe", pc_next, 16'hFFFE);
        tick();
        chk("wrap addr 0", imem_addr, 16'h0000);
        chk("wrap inst", pc_inst, 16'h1FFF);
        chk("wrap pcn 0", pc_next, 16'h0000);
        $display("wrap: addr=%h pcn=%h", imem_addr, pc_next);

        // Reset during a slow request
        do_reset();
        imem_rdy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("t6 req", 16'(imem_req), 16'd0);
        chk("t6 valid", 16'(inst_valid), 16'd0);
        chk("t6 halted", 16'(halted), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("t6 restart req", 16'(imem_req), 16'd1);
        chk("t6 restart addr", imem_addr, RESET_PC);
        $display("reset mid-request: req=%b addr=%h", imem_req, imem_addr);

        // Random traffic against the model
        for (int w = 0; w < 32768; w++) mem[w] = 16'($urandom);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst_n       = ($urandom_range(0, 499) != 0);
            stall       = ($urandom_range(0, 9) < 3);
            imem_rdy    = $urandom_range(0, 1) == 1;
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            tick();
            if (c % 500 == 0)
                $display("random cycle %0d: checks=%0d fails=%0d", c, n_chk, n_fail);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
